// File: rtl/dmem_bus_bridge.sv
// Mem-stage data port to valid/ready bus bridge; best case 3 stall cycles (request, accept, response).
// Request is held stable until ready; pipeline held via stall_out; a missing response ends in a timeout fault.
module dmem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [63:0] data_address_in,
  input  logic [63:0] data_write_value_in,
  input  logic [7:0]  data_write_mask_in,
  output logic [63:0] data_read_value_out,
  output logic        stall_out,
  output logic        fault_out,
  output logic [63:0] fault_addr_out,
  output logic        bus_req_valid_out,
  input  logic        bus_req_ready_in,
  output logic        bus_req_write_out,
  output logic [63:0] bus_req_addr_out,
  output logic [63:0] bus_req_wdata_out,
  output logic [7:0]  bus_req_mask_out,
  input  logic        bus_resp_valid_in,
  input  logic [63:0] bus_resp_rdata_in,
  input  logic        bus_resp_error_in
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [63:0] faddr_q, faddr_d;
  logic        req;

  assign req = data_read_in | data_write_in;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // a simultaneous read+write is treated as the write
          wr_d    = data_write_in;
          addr_d  = data_address_in;
          wdata_d = data_write_value_in;
          mask_d  = data_write_in ? data_write_mask_in : 8'hFF;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_req_ready_in) begin
          cnt_d   = 32'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_resp_valid_in) begin
          err_d   = bus_resp_error_in;
          state_d = S_DONE;
          if (bus_resp_error_in) begin
            rdata_d = 64'd0;
            faddr_d = addr_q;
          end else if (!wr_q) begin
            rdata_d = bus_resp_rdata_in;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = 64'd0;
          faddr_d = addr_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        if (!stall_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      mask_q  <= 8'd0;
      cnt_q   <= 32'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      faddr_q <= 64'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
    end
  end

  assign stall_out           = ((state_q == S_IDLE) && req) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign fault_out           = (state_q == S_DONE) && err_q;
  assign fault_addr_out      = faddr_q;
  assign data_read_value_out = rdata_q;
  assign bus_req_valid_out   = (state_q == S_REQ);
  assign bus_req_write_out   = wr_q;
  assign bus_req_addr_out    = {addr_q[63:3], 3'b000};
  assign bus_req_wdata_out   = wdata_q;
  assign bus_req_mask_out    = mask_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: each access is described by its bus timing (ready delay, response latency,
// error, DONE hold) and the expected per-cycle outputs are derived from that schedule arithmetically.
module tb_dmem_bus_bridge;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in;
  logic        data_read_in, data_write_in;
  logic [63:0] data_address_in, data_write_value_in;
  logic [7:0]  data_write_mask_in;
  logic [63:0] data_read_value_out;
  logic        stall_out, fault_out;
  logic [63:0] fault_addr_out;
  logic        bus_req_valid_out, bus_req_ready_in, bus_req_write_out;
  logic [63:0] bus_req_addr_out, bus_req_wdata_out;
  logic [7:0]  bus_req_mask_out;
  logic        bus_resp_valid_in, bus_resp_error_in;
  logic [63:0] bus_resp_rdata_in;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
    .data_read_in(data_read_in), .data_write_in(data_write_in),
    .data_address_in(data_address_in), .data_write_value_in(data_write_value_in),
    .data_write_mask_in(data_write_mask_in), .data_read_value_out(data_read_value_out),
    .stall_out(stall_out), .fault_out(fault_out), .fault_addr_out(fault_addr_out),
    .bus_req_valid_out(bus_req_valid_out), .bus_req_ready_in(bus_req_ready_in),
    .bus_req_write_out(bus_req_write_out), .bus_req_addr_out(bus_req_addr_out),
    .bus_req_wdata_out(bus_req_wdata_out), .bus_req_mask_out(bus_req_mask_out),
    .bus_resp_valid_in(bus_resp_valid_in), .bus_resp_rdata_in(bus_resp_rdata_in),
    .bus_resp_error_in(bus_resp_error_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // expected outputs for the current cycle
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_valid, exp_fault, exp_wr, exp_chk_faddr;
  logic [63:0] exp_data, exp_addr, exp_wd, exp_faddr;
  logic [7:0]  exp_mask;
  logic [63:0] model_rd = 64'd0;

  // observations used by the literal pins
  int          stall_seen = 0, valid_seen = 0, fault_seen = 0;
  logic [63:0] seen_addr = 64'd0, seen_faddr = 64'd0;
  logic [7:0]  seen_mask = 8'd0;
  logic        seen_wr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_out", 64'(stall_out), 64'(exp_stall));
      check("bus_req_valid", 64'(bus_req_valid_out), 64'(exp_valid));
      check("fault_out", 64'(fault_out), 64'(exp_fault));
      check("read_value", data_read_value_out, exp_data);
      if (exp_valid) begin
        check("bus_req_write", 64'(bus_req_write_out), 64'(exp_wr));
        check("bus_req_addr", bus_req_addr_out, exp_addr);
        check("bus_req_mask", 64'(bus_req_mask_out), 64'(exp_mask));
        if (exp_wr) check("bus_req_wdata", bus_req_wdata_out, exp_wd);
      end
      if (exp_chk_faddr) check("fault_addr", fault_addr_out, exp_faddr);
      if (stall_out) stall_seen++;
      if (bus_req_valid_out) begin
        valid_seen++;
        seen_addr = bus_req_addr_out;
        seen_mask = bus_req_mask_out;
        seen_wr   = bus_req_write_out;
      end
      if (fault_out) begin
        fault_seen++;
        seen_faddr = fault_addr_out;
      end
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic set_quiet_exp();
    exp_stall = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0;
    exp_chk_faddr = 1'b0; exp_data = model_rd;
  endtask

  // Access schedule: cycle 0 request in IDLE, REQ for dr not-ready cycles then accepted,
  // response lat cycles after acceptance (0 = never), DONE held by stall_in for hold cycles.
  task automatic do_txn(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] mk, input int dr, input int lat, input bit err,
                        input logic [63:0] rdat, input int hold);
    int a, w, d;
    bit to, eerr;
    logic [63:0] nrd;
    a    = 1 + dr;
    to   = !(lat >= 1 && lat <= T);
    w    = to ? T : lat;
    eerr = to | err;
    d    = a + w + 1;
    nrd  = eerr ? 64'd0 : (wr ? model_rd : rdat);
    for (int c = 0; c <= d + hold; c++) begin
      data_read_in        = rd;
      data_write_in       = wr;
      data_address_in     = (c == 0) ? addr : rnd64();
      data_write_value_in = (c == 0) ? wd : rnd64();
      data_write_mask_in  = (c == 0) ? mk : 8'($urandom());
      if (c == a)                bus_req_ready_in = 1'b1;
      else if (c >= 1 && c < a)  bus_req_ready_in = 1'b0;
      else                       bus_req_ready_in = 1'($urandom() % 2);
      if (lat != 0 && c == a + lat) begin
        bus_resp_valid_in = 1'b1; bus_resp_rdata_in = rdat; bus_resp_error_in = err;
      end else begin
        bus_resp_valid_in = (c <= a) ? 1'($urandom() % 2) : 1'b0;
        bus_resp_rdata_in = rnd64();
        bus_resp_error_in = 1'($urandom() % 2);
      end
      stall_in      = (c >= d) ? (c < d + hold) : 1'($urandom() % 2);
      exp_stall     = (c < d);
      exp_valid     = (c >= 1 && c <= a);
      exp_wr        = wr;
      exp_addr      = {addr[63:3], 3'b000};
      exp_mask      = wr ? mk : 8'hFF;
      exp_wd        = wd;
      exp_fault     = (c >= d) && eerr;
      exp_chk_faddr = exp_fault;
      exp_faddr     = addr;
      exp_data      = (c >= d) ? nrd : model_rd;
      @(posedge clk); #1;
    end
    model_rd = nrd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data_read_in = 1'b0; data_write_in = 1'b0;
      data_address_in = rnd64(); data_write_value_in = rnd64(); data_write_mask_in = 8'($urandom());
      bus_req_ready_in  = 1'($urandom() % 2);
      bus_resp_valid_in = 1'($urandom() % 2);
      bus_resp_rdata_in = rnd64();
      bus_resp_error_in = 1'($urandom() % 2);
      stall_in = 1'($urandom() % 2);
      set_quiet_exp();
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_reset_values();
    exp_stall = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0;
    exp_data = 64'd0; exp_chk_faddr = 1'b1; exp_faddr = 64'd0;
  endtask

  initial begin
    int s0, v0, f0, op, hold;
    logic [63:0] ad;
    reset_n = 1'b0; stall_in = 1'b0;
    data_read_in = 1'b0; data_write_in = 1'b0;
    data_address_in = '0; data_write_value_in = '0; data_write_mask_in = '0;
    bus_req_ready_in = 1'b0; bus_resp_valid_in = 1'b0;
    bus_resp_rdata_in = '0; bus_resp_error_in = 1'b0;
    expect_reset_values();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // read 0x1004, immediate ready, response next cycle
    s0 = stall_seen;
    do_txn(1'b1, 1'b0, 64'h1004, 64'd0, 8'h00, 0, 1, 1'b0, 64'hDEADBEEF_01234567, 0);
    idle(1);
    check("t1_stall_cycles", 64'(stall_seen - s0), 64'd3);
    check("t1_bus_addr", seen_addr, 64'h1000);
    check("t1_bus_mask", 64'(seen_mask), 64'hFF);
    check("t1_read_value", data_read_value_out, 64'hDEADBEEF_01234567);

    // write 0x2002 mask 0x0C, ready low for 4 REQ cycles, ack 2 cycles later
    s0 = stall_seen; f0 = fault_seen;
    do_txn(1'b0, 1'b1, 64'h2002, 64'h0000_0000_AABB_0000, 8'h0C, 4, 2, 1'b0, rnd64(), 0);
    idle(1);
    check("t2_stall_cycles", 64'(stall_seen - s0), 64'd8);
    check("t2_bus_write", 64'(seen_wr), 64'd1);
    check("t2_bus_addr", seen_addr, 64'h2000);
    check("t2_bus_mask", 64'(seen_mask), 64'h0C);
    check("t2_fault_cycles", 64'(fault_seen - f0), 64'd0);

    // read with no response: times out after T wait cycles
    s0 = stall_seen; f0 = fault_seen;
    do_txn(1'b1, 1'b0, 64'h5008, 64'd0, 8'h00, 0, 0, 1'b0, 64'd0, 0);
    idle(1);
    check("t3_stall_cycles", 64'(stall_seen - s0), 64'd6);
    check("t3_fault_cycles", 64'(fault_seen - f0), 64'd1);
    check("t3_fault_addr", seen_faddr, 64'h5008);
    check("t3_read_value", data_read_value_out, 64'd0);

    // error response on a write of 0x3000
    f0 = fault_seen;
    do_txn(1'b0, 1'b1, 64'h3000, 64'h1234, 8'h03, 0, 1, 1'b1, 64'd0, 0);
    idle(1);
    check("t4_fault_cycles", 64'(fault_seen - f0), 64'd1);
    check("t4_fault_addr", seen_faddr, 64'h3000);

    // back-to-back loads, first DONE held by stall_in for 2 cycles
    v0 = stall_seen; s0 = valid_seen; f0 = fault_seen;
    do_txn(1'b1, 1'b0, 64'h4010, 64'd0, 8'h00, 0, 1, 1'b0, 64'h1111_2222_3333_4444, 2);
    do_txn(1'b1, 1'b0, 64'h4018, 64'd0, 8'h00, 0, 1, 1'b0, 64'h5555_6666_7777_8888, 0);
    idle(1);
    check("t5_valid_cycles", 64'(valid_seen - s0), 64'd2);
    check("t5_stall_cycles", 64'(stall_seen - v0), 64'd6);
    check("t5_read_value", data_read_value_out, 64'h5555_6666_7777_8888);

    // reset asserted in WAIT, response arrives after release
    f0 = fault_seen;
    data_read_in = 1'b1; data_write_in = 1'b0; data_address_in = 64'h6000;
    bus_req_ready_in = 1'b0; bus_resp_valid_in = 1'b0; stall_in = 1'b0;
    set_quiet_exp(); exp_stall = 1'b1;
    @(posedge clk); #1;
    bus_req_ready_in = 1'b1;
    exp_valid = 1'b1; exp_wr = 1'b0; exp_addr = 64'h6000; exp_mask = 8'hFF;
    @(posedge clk); #1;
    bus_req_ready_in = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; data_read_in = 1'b0;
    model_rd = 64'd0;
    expect_reset_values();
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_resp_valid_in = 1'b1; bus_resp_rdata_in = rnd64(); bus_resp_error_in = 1'b1;
    @(posedge clk); #1;
    bus_resp_valid_in = 1'b0;
    @(posedge clk); #1;
    exp_chk_faddr = 1'b0;
    check("t6_fault_cycles", 64'(fault_seen - f0), 64'd0);
    check("t6_read_value", data_read_value_out, 64'd0);

    // randomized accesses
    for (int k = 0; k < 200; k++) begin
      op   = int'($urandom_range(0, 2));
      ad   = rnd64();
      hold = int'($urandom_range(0, 2));
      do_txn(op != 1, op != 0, ad, rnd64(), 8'($urandom()), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 5)), ($urandom() % 4) == 0, rnd64(), hold);
      idle(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
